// File: rtl/dram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_bus_arbiter
// Description : Two-port arbiter for the ip_sdram request bus, one outstanding
//               transaction, read-return steering and read timeout.
//               Optional: DRAM_BUS_ARBITER_ROUND_ROBIN_EN (round-robin on tie).
// Revision    : 1.0
// ============================================================================
module dram_bus_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              initial_busy,

    input  logic [ADDR_W-1:0] req0_address,
    input  logic              req0_write,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [127:0]      req0_wdata,
    input  logic [15:0]       req0_wdata_mask,
    output logic              req0_rdata_en,

    input  logic [ADDR_W-1:0] req1_address,
    input  logic              req1_write,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [127:0]      req1_wdata,
    input  logic [15:0]       req1_wdata_mask,
    output logic              req1_rdata_en,

    output logic [127:0]      rdata,

    output logic [ADDR_W-1:0] dram_address,
    output logic              dram_write,
    output logic              dram_valid,
    input  logic              dram_ready,
    output logic [127:0]      dram_wdata,
    output logic [15:0]       dram_wdata_mask,
    input  logic [127:0]      dram_rdata,
    input  logic              dram_rdata_en,

    output logic              timeout_flag
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GNT0 = 3'd1,
        S_GNT1 = 3'd2,
        S_RD0  = 3'd3,
        S_RD1  = 3'd4
    } state_t;

    localparam logic [7:0] c_TO_LAST = 8'(RD_TIMEOUT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last_grant;
    logic         w_last_nxt;
    logic [7:0]   r_cnt;
    logic [7:0]   w_cnt_nxt;
    logic         r_timeout_flag;
    logic [127:0] r_rdata;
    logic         r_rdata_en0;
    logic         r_rdata_en1;
    logic         w_pick;
    logic         w_rd_hit;
    logic         w_rd_to;

    // w_pick: 0 selects port 0, 1 selects port 1
    always_comb begin
`ifdef DRAM_BUS_ARBITER_ROUND_ROBIN_EN
        w_pick = (req0_valid && req1_valid) ? ~r_last_grant : ~req0_valid;
`else
        w_pick = ~req0_valid;
`endif
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last_grant;
        w_cnt_nxt       = r_cnt;
        w_rd_hit        = 1'b0;
        w_rd_to         = 1'b0;
        dram_valid      = 1'b0;
        dram_address    = '0;
        dram_write      = 1'b0;
        dram_wdata      = '0;
        dram_wdata_mask = '0;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!initial_busy && (req0_valid || req1_valid)) begin
                    w_state_nxt = w_pick ? S_GNT1 : S_GNT0;
                    w_last_nxt  = w_pick;
                end
            end
            S_GNT0: begin
                dram_address    = req0_address;
                dram_write      = req0_write;
                dram_wdata      = req0_wdata;
                dram_wdata_mask = req0_wdata_mask;
                dram_valid      = req0_valid;
                req0_ready      = dram_ready;
                if (req0_valid && dram_ready) begin
                    w_state_nxt = req0_write ? S_IDLE : S_RD0;
                    w_cnt_nxt   = '0;
                end else if (!req0_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GNT1: begin
                dram_address    = req1_address;
                dram_write      = req1_write;
                dram_wdata      = req1_wdata;
                dram_wdata_mask = req1_wdata_mask;
                dram_valid      = req1_valid;
                req1_ready      = dram_ready;
                if (req1_valid && dram_ready) begin
                    w_state_nxt = req1_write ? S_IDLE : S_RD1;
                    w_cnt_nxt   = '0;
                end else if (!req1_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD0, S_RD1: begin
                // Real data wins over a timeout landing on the same cycle
                if (dram_rdata_en) begin
                    w_rd_hit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_rd_to     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant   <= 1'b1;
            r_cnt          <= '0;
            r_timeout_flag <= 1'b0;
            r_rdata        <= '0;
            r_rdata_en0    <= 1'b0;
            r_rdata_en1    <= 1'b0;
        end else begin
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rdata_en0  <= (w_rd_hit || w_rd_to) && (r_state == S_RD0);
            r_rdata_en1  <= (w_rd_hit || w_rd_to) && (r_state == S_RD1);
            if (w_rd_hit) begin
                r_rdata <= dram_rdata;
            end else if (w_rd_to) begin
                r_rdata <= '0;
            end
            if (w_rd_to) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    assign req0_rdata_en = r_rdata_en0;
    assign req1_rdata_en = r_rdata_en1;
    assign rdata         = r_rdata;
    assign timeout_flag  = r_timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_dram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_bus_arbiter
// Description : Directed self-checking bench for dram_bus_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_dram_bus_arbiter;

    localparam int c_ADDR_W = 27;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                initial_busy;
    logic [c_ADDR_W-1:0] req0_address, req1_address;
    logic                req0_write, req1_write;
    logic                req0_valid, req1_valid;
    logic                req0_ready, req1_ready;
    logic [127:0]        req0_wdata, req1_wdata;
    logic [15:0]         req0_wdata_mask, req1_wdata_mask;
    logic                req0_rdata_en, req1_rdata_en;
    logic [127:0]        rdata;
    logic [c_ADDR_W-1:0] dram_address;
    logic                dram_write, dram_valid, dram_ready;
    logic [127:0]        dram_wdata;
    logic [15:0]         dram_wdata_mask;
    logic [127:0]        dram_rdata;
    logic                dram_rdata_en;
    logic                timeout_flag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dram_bus_arbiter #(.ADDR_W(c_ADDR_W), .RD_TIMEOUT(255)) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .initial_busy    (initial_busy),
        .req0_address    (req0_address),
        .req0_write      (req0_write),
        .req0_valid      (req0_valid),
        .req0_ready      (req0_ready),
        .req0_wdata      (req0_wdata),
        .req0_wdata_mask (req0_wdata_mask),
        .req0_rdata_en   (req0_rdata_en),
        .req1_address    (req1_address),
        .req1_write      (req1_write),
        .req1_valid      (req1_valid),
        .req1_ready      (req1_ready),
        .req1_wdata      (req1_wdata),
        .req1_wdata_mask (req1_wdata_mask),
        .req1_rdata_en   (req1_rdata_en),
        .rdata           (rdata),
        .dram_address    (dram_address),
        .dram_write      (dram_write),
        .dram_valid      (dram_valid),
        .dram_ready      (dram_ready),
        .dram_wdata      (dram_wdata),
        .dram_wdata_mask (dram_wdata_mask),
        .dram_rdata      (dram_rdata),
        .dram_rdata_en   (dram_rdata_en),
        .timeout_flag    (timeout_flag)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int order[4];
        int want_order[4];
        int got_n;
        int rem0;
        int rem1;
        int g;
        int hit_at;

        reset_n = 1'b0; initial_busy = 1'b0;
        req0_address = '0; req0_write = 1'b0; req0_valid = 1'b0;
        req0_wdata = '0; req0_wdata_mask = '0;
        req1_address = '0; req1_write = 1'b0; req1_valid = 1'b0;
        req1_wdata = '0; req1_wdata_mask = '0;
        dram_ready = 1'b0; dram_rdata = '0; dram_rdata_en = 1'b0;

        // Reset state
        #3;
        check("rst_dram_valid", dram_valid, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rden0", req0_rdata_en, 0);
        check("rst_rden1", req1_rdata_en, 0);
        check("rst_rdata", rdata, 0);
        check("rst_timeout", timeout_flag, 0);
        step();
        reset_n = 1'b1;

        // Init gate
        initial_busy = 1'b1;
        req0_valid = 1'b1; req0_address = 27'h0001234; req0_write = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("init_gate_valid", dram_valid, 0);
        end
        initial_busy = 1'b0;
        #1;
        check("init_release_same_cycle", dram_valid, 0);
        step();
        check("init_release_valid", dram_valid, 1);
        check("init_release_addr", dram_address, 27'h0001234);
        req0_valid = 1'b0;
        #1;
        check("abandon0_valid", dram_valid, 0);
        step();

        // Port 0 write
        req0_valid = 1'b1; req0_write = 1'b1;
        req0_wdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5;
        req0_wdata_mask = 16'hFFFE;
        dram_ready = 1'b1;
        #1;
        check("wr0_idle_valid", dram_valid, 0);
        step();
        check("wr0_valid", dram_valid, 1);
        check("wr0_ready0", req0_ready, 1);
        check("wr0_ready1", req1_ready, 0);
        check("wr0_write", dram_write, 1);
        check("wr0_wdata", dram_wdata, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5);
        check("wr0_mask", dram_wdata_mask, 16'hFFFE);
        step();
        check("wr0_back_idle_valid", dram_valid, 0);
        check("wr0_back_idle_ready", req0_ready, 0);
        req0_valid = 1'b0; req0_write = 1'b0;

        // Port 1 read
        req1_valid = 1'b1; req1_write = 1'b0; req1_address = 27'h0ABCDEF;
        step();
        check("rd1_valid", dram_valid, 1);
        check("rd1_ready1", req1_ready, 1);
        check("rd1_ready0", req0_ready, 0);
        check("rd1_addr", dram_address, 27'h0ABCDEF);
        step();
        req1_valid = 1'b0;
        #1;
        check("rd1_wait_valid", dram_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rd1_early_rden", req1_rdata_en, 0);
        end
        dram_rdata_en = 1'b1;
        dram_rdata = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98;
        step();
        dram_rdata_en = 1'b0;
        check("rd1_rden1", req1_rdata_en, 1);
        check("rd1_rden0", req0_rdata_en, 0);
        check("rd1_rdata", rdata, 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98);
        step();
        check("rd1_pulse_one", req1_rdata_en, 0);

        // Late data is ignored
        dram_rdata_en = 1'b1; dram_rdata = 128'h5555;
        step();
        dram_rdata_en = 1'b0;
        check("late_rden0", req0_rdata_en, 0);
        check("late_rden1", req1_rdata_en, 0);
        check("late_rdata", rdata, 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98);

        // Simultaneous requests, two reads each
`ifdef DRAM_BUS_ARBITER_ROUND_ROBIN_EN
        want_order = '{0, 1, 0, 1};
`else
        want_order = '{0, 0, 1, 1};
`endif
        order = '{default: -1};
        got_n = 0; rem0 = 2; rem1 = 2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int budget = 0; budget < 200 && got_n < 4; budget++) begin
            if (dram_valid && dram_ready) begin
                g = req1_ready ? 1 : 0;
                order[got_n] = g;
                got_n++;
                step();
                if (g == 0) begin
                    rem0--;
                    if (rem0 == 0) req0_valid = 1'b0;
                end else begin
                    rem1--;
                    if (rem1 == 0) req1_valid = 1'b0;
                end
                dram_rdata_en = 1'b1; dram_rdata = 128'(got_n);
                step();
                dram_rdata_en = 1'b0;
            end else begin
                step();
            end
        end
        check("arb_count", got_n, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_order%0d", i), order[i], want_order[i]);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Timeout on port 0
        req0_valid = 1'b1; req0_write = 1'b0; req0_address = 27'h0000777;
        step();
        check("to_grant0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        check("to_flag_before", timeout_flag, 0);
        hit_at = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (req0_rdata_en) begin
                hit_at = i;
                break;
            end
        end
        check("to_latency", hit_at, 255);
        check("to_rdata", rdata, 0);
        check("to_flag", timeout_flag, 1);
        check("to_rden1", req1_rdata_en, 0);

        req1_valid = 1'b1; req1_write = 1'b1; req1_wdata = 128'h77; req1_wdata_mask = 16'h00FF;
        step();
        check("to_wr1_ready", req1_ready, 1);
        check("to_wr1_wdata", dram_wdata, 128'h77);
        step();
        req1_valid = 1'b0; req1_write = 1'b0;
        check("to_flag_sticky", timeout_flag, 1);
        check("to_wr1_done", dram_valid, 0);

        // Abandoned request on port 1
        dram_ready = 1'b0;
        req1_valid = 1'b1; req1_address = 27'h0000042;
        step();
        check("ab_valid", dram_valid, 1);
        check("ab_ready", req1_ready, 0);
        req1_valid = 1'b0;
        #1;
        check("ab_drop_valid", dram_valid, 0);
        step();
        dram_ready = 1'b1;
        #1;
        check("ab_idle_ready", req1_ready, 0);
        check("ab_idle_valid", dram_valid, 0);

        // Async reset during RD0
        req0_valid = 1'b1; req0_address = 27'h0000099;
        step();
        step();
        req0_valid = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_timeout", timeout_flag, 0);
        check("ar_valid", dram_valid, 0);
        check("ar_rden0", req0_rdata_en, 0);
        check("ar_rdata", rdata, 0);
        check("ar_addr", dram_address, 0);
        step();
        reset_n = 1'b1;
        dram_rdata_en = 1'b1;
        step();
        dram_rdata_en = 1'b0;
        check("ar_no_rden0", req0_rdata_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
